// File: rtl/apb3_slave_mem.sv
// apb3_slave_mem: APB3 completer fronting a word-addressed register memory with wait states, a read-only region and PSLVERR
module apb3_slave_mem #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          DEPTH       = 16,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int          WAIT_CYCLES = 0,
    parameter int          RO_WORDS    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int BYTES   = DATA_WIDTH / 8;
    localparam int OFF_LSB = $clog2(BYTES);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int SPAN    = DEPTH * BYTES;
    localparam int CNT_W   = 8;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    pwrite_q, pwrite_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rd_q, rd_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    mem_we;

    logic [ADDR_WIDTH-1:0]   offset;
    logic [IDX_W-1:0]        setup_idx;
    logic                    out_of_range;
    logic                    misaligned;
    logic                    ro_hit;
    logic                    setup_err;

    // Address decode used only at setup; an address below BASE_ADDR wraps to a huge offset and fails the range test
    always_comb begin
        offset       = paddr - ADDR_WIDTH'(BASE_ADDR);
        setup_idx    = IDX_W'(offset >> OFF_LSB);
        out_of_range = {1'b0, offset} >= (ADDR_WIDTH + 1)'(SPAN);
        misaligned   = |(offset & ADDR_WIDTH'(BYTES - 1));
        setup_err    = out_of_range || misaligned || (pwrite && ro_hit);
    end

    if (RO_WORDS == 0) begin : g_no_ro
        assign ro_hit = 1'b0;
    end else begin : g_ro
        assign ro_hit = {1'b0, setup_idx} < (IDX_W + 1)'(RO_WORDS);
    end

    // Next-state logic: latch the transfer at setup, count wait cycles, complete or abort in ACCESS
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        pwrite_d = pwrite_q;
        err_d    = err_q;
        rd_d     = rd_q;
        mem_we   = 1'b0;
        if (state_q == IDLE) begin
            if (psel && !penable) begin
                state_d  = ACCESS;
                cnt_d    = CNT_W'(WAIT_CYCLES);
                idx_d    = setup_idx;
                pwrite_d = pwrite;
                err_d    = setup_err;
                rd_d     = setup_err ? '0 : mem_q[setup_idx];
            end
        end else if (!psel) begin
            state_d = IDLE;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (penable) begin
            mem_we  = pwrite_q && !err_q;
            state_d = IDLE;
        end
    end

    // Transfer state registers; reset drops any in-flight transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            pwrite_q <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pwrite_q <= pwrite_d;
            err_q    <= err_d;
            rd_q     <= rd_d;
        end
    end

    // Word storage: cleared by reset, written with the data present in the completing cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[idx_q] <= pwdata;
        end
    end

    assign pready  = (state_q == ACCESS) && (cnt_q == '0);
    assign pslverr = pready && err_q;
    assign prdata  = (pready && !pwrite_q && !err_q) ? rd_q : '0;

endmodule
